// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier: condition-code bit positions
// and the per-op control/passthrough record. MUL_ACC_EN adds the accumulate flag.
package mul_pkg;

    localparam int MUL_AW  = 32;
    localparam int MUL_TW  = 12;
    localparam int CC_OVF  = 1;
    localparam int CC_ZERO = 0;

    // Field widths follow MUL_AW/MUL_TW; the top's AW/TW default to these.
    typedef struct packed {
        logic              tag;
        logic              sat;
`ifdef MUL_ACC_EN
        logic              acc;
`endif
        logic [MUL_AW-1:0] opr0;
        logic [MUL_TW-1:0] gen;
    } mul_op_t;

endpackage

// File: rtl/mul_pipe_reg.sv
// One elastic pipeline stage: a valid bit plus a data word, loading whenever
// the stage is empty or its current contents are leaving downstream.
module mul_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] d,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] q
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign up_ready = ~valid_q | dn_ready;
    assign dn_valid = valid_q;
    assign q        = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_multiplier.sv
// Pipelined signed multiplier with saturation, {ovf, zero} flags and tag mode.
// Optional accumulator enabled by defining MUL_ACC_EN.
module pipe_multiplier
    import mul_pkg::*;
#(
    parameter int AW     = MUL_AW,
    parameter int BW     = 16,
    parameter int TW     = MUL_TW,
    parameter int STAGES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] opr0,
    input  logic [BW-1:0] opr1,
    input  logic [BW-1:0] imm16,
    input  logic [TW-1:0] gen,
    input  logic          tag,
    input  logic          sat,
    input  logic          r_sel,
    input  logic          imm_sel,
`ifdef MUL_ACC_EN
    input  logic          acc,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] rslt,
    output logic [1:0]    rslt_cc,
    output logic [TW-1:0] rslt_tag
);

    localparam int PW  = AW + BW;
    localparam int OPW = $bits(mul_op_t);
    localparam int CW  = PW + 1 + OPW;
    localparam int OW  = AW + 2 + TW;
`ifdef MUL_ACC_EN
    localparam int VW  = PW + 1;
`else
    localparam int VW  = PW;
`endif

    logic signed [AW-1:0] a_s;
    logic signed [BW-1:0] b_s;
    logic signed [PW-1:0] p_s;
    logic                 zero_in;
    mul_op_t              op_in;

    always_comb begin
        a_s     = tag ? {{(AW-TW){1'b0}}, gen} : opr0;
        b_s     = r_sel ? (imm_sel ? {{(BW-5){1'b0}}, imm16[4:0]} : imm16) : opr1;
        p_s     = PW'(a_s) * PW'(b_s);
        zero_in = (a_s == '0) | (b_s == '0);
        op_in      = '0;
        op_in.tag  = tag;
        op_in.sat  = sat;
        op_in.opr0 = opr0;
        op_in.gen  = gen;
`ifdef MUL_ACC_EN
        op_in.acc  = acc;
`endif
    end

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [CW-1:0]   cd [STAGES];

    assign vld[0]      = in_valid;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    assign out_valid   = vld[STAGES];
    assign cd[0]       = {p_s, zero_in, op_in};

    // Product and op record ride unchanged through all but the last stage.
    for (genvar i = 0; i < STAGES - 1; i++) begin : g_carry
        mul_pipe_reg #(.W(CW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[i]),
            .up_ready (rdy[i]),
            .d        (cd[i]),
            .dn_valid (vld[i+1]),
            .dn_ready (rdy[i+1]),
            .q        (cd[i+1])
        );
    end

    logic signed [PW-1:0] f_p;
    logic                 f_zero;
    mul_op_t              f_op;
    logic signed [VW-1:0] f_val;
    logic [AW-1:0]        f_rslt;
    logic [TW-1:0]        f_tag;
    logic [1:0]           f_cc;
    logic [OW-1:0]        out_d;
    logic [OW-1:0]        out_q;

    assign {f_p, f_zero, f_op} = cd[STAGES-1];

`ifdef MUL_ACC_EN
    logic signed [VW-1:0] acc_q;
    logic signed [VW-1:0] acc_d;
    logic                 f_load;

    assign f_load = vld[STAGES-1] & rdy[STAGES-1];
    assign acc_d  = f_op.acc ? acc_q + {f_p[PW-1], f_p} : {f_p[PW-1], f_p};
    assign f_val  = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (f_load && !f_op.tag) begin
            acc_q <= acc_d;
        end
    end
`else
    assign f_val = f_p;
`endif

    always_comb begin
        f_cc          = '0;
        f_cc[CC_ZERO] = f_zero;
        if (f_op.tag) begin
            f_rslt       = f_op.opr0;
            f_tag        = f_p[TW-1:0];
            f_cc[CC_OVF] = |f_p[PW-1:TW];
        end else begin
            f_tag        = f_op.gen;
            // In range only when every bit from the result MSB upward matches.
            f_cc[CC_OVF] = ~((&f_val[VW-1:AW-1]) | ~(|f_val[VW-1:AW-1]));
            if (f_op.sat && f_cc[CC_OVF]) begin
                f_rslt = f_val[VW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                f_rslt = f_val[AW-1:0];
            end
        end
        out_d = {f_rslt, f_cc, f_tag};
    end

    mul_pipe_reg #(.W(OW)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (vld[STAGES-1]),
        .up_ready (rdy[STAGES-1]),
        .d        (out_d),
        .dn_valid (vld[STAGES]),
        .dn_ready (rdy[STAGES]),
        .q        (out_q)
    );

    assign {rslt, rslt_cc, rslt_tag} = out_q;

endmodule

// File: doc/pipe_multiplier.md
# pipe_multiplier

Parametrised, pipelined signed multiplier for the integer execution unit, successor to the single-cycle combinational multiplier. It takes one operation per cycle through a valid/ready handshake, produces a saturating or wrapping product plus a 2-bit condition code, and supports tag mode, where the generation field is multiplied instead of the data operand. The result appears after a fixed, parametrised latency, with full backpressure support so it can sit between the issue stage and the write-back arbiter.

## Interface
- AW, 32: width of operand A and of the result
- BW, 16: width of operand B and of the immediate
- TW, 12: width of the generation/tag field
- STAGES, 3: pipeline depth (≥1); equals latency when there is no backpressure
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1  input handshake
- opr0  in  AW  signed operand A
- opr1  in  BW  signed register operand B
- imm16  in  BW  signed immediate
- gen  in  TW  generation field
- tag  in  1  tag mode
- sat  in  1  saturate on overflow
- r_sel  in  1  0: use opr1; 1: use the immediate
- imm_sel  in  1  0: use imm16 as is; 1: use zero-extended imm16[4:0]
- acc  in  1  accumulate (present only with MUL_ACC_EN)
- out_valid / out_ready  out / in  1  output handshake
- rslt  out  AW  result
- rslt_cc  out  2  {ovf, zero}
- rslt_tag  out  TW  tag result

## Operation
- **Operand selection**
  - A = tag ? zero-extend(gen) : opr0.
  - B = r_sel ? (imm_sel ? zero-extend(imm16[4:0]) : imm16) : opr1.
- **Product:** P = A*B, signed, AW+BW bits, exact.
- **zero** = (A == 0) | (B == 0).
- **Normal mode**
  - ovf = 1 when P lies outside [−2^(AW−1), 2^(AW−1)−1].
  - Result when sat=1 and ovf=1: clamp to 2^(AW−1)−1 if P>0, or −2^(AW−1) if P<0.
  - Result otherwise: P[AW−1:0].
  - rslt_tag = gen, passed through.
- **Tag mode**
  - rslt = opr0, passed through.
  - rslt_tag = P[TW−1:0].
  - ovf = |P[AW+BW−1:TW].
  - sat is ignored.
- **Pipeline control**
  - Elastic pipeline: each stage has its own valid bit and loads when it is empty or its contents are moving on.
  - in_ready = ~v[0] | advance[0]. No bubbles are required; throughput is 1 op per cycle.
  - Order is preserved. No operation is dropped or duplicated.
  - out_valid, rslt, rslt_cc and rslt_tag are held stable while out_valid & ~out_ready.
- **Reset:** all valid bits, data registers and the accumulator go to 0, so out_valid=0, rslt=0, rslt_cc=0, rslt_tag=0. In-flight operations are discarded with no output.

## Timing
- Operation accepted in cycle n, with no stall: out_valid=1 in cycle n+STAGES.
- The multiplication may be split freely across stages 0..STAGES−2. The final stage is the output register, and saturation, flags and accumulation are computed while it loads.
- out_ready low for k cycles stalls the pipeline by k. in_ready falls once all STAGES slots are full and rises in the same cycle that out_ready rises (combinational path out_ready→in_ready allowed).
- Simultaneous accept and retire on a full pipe is legal and sustains full rate.

## Configuration
- **MUL_ACC_EN defined**
  - Adds the acc port and an (AW+BW+1)-bit two's-complement accumulator register that wraps.
  - Normal-mode op with acc=0: accumulator := P.
  - Normal-mode op with acc=1: accumulator := accumulator + P.
  - The update happens when the op loads the final stage. The result, ovf and saturation are then computed from the new accumulator value instead of from P.
  - zero keeps the operand-based definition.
  - Tag-mode ops leave the accumulator unchanged.
- **MUL_ACC_EN undefined:** no acc port and no accumulator; behaviour is exactly as in Operation.

## Structure
- Shared package mul_pkg holds:
  - CC_OVF=1 and CC_ZERO=0 bit indices;
  - the packed op struct that travels down the pipe: tag, sat, opr0 passthrough, gen, and, with MUL_ACC_EN, acc.
- Sub-module mul_pipe_reg is one elastic stage (valid, data, advance logic); it is instantiated STAGES times, and the arithmetic lives in pipe_multiplier.

## Test plan
All scenarios use the default parameters (AW=32, BW=16, TW=12, STAGES=3).
- opr0=1000, opr1=−3, r_sel=0, sat=0 -> rslt=0xFFFFF448, cc=00, out_valid exactly 3 cycles after accept.
- opr0=0x40000000, opr1=4: sat=1 -> 0x7FFFFFFF, cc=10; sat=0 -> 0x00000000, cc=10; opr0=0x80000000, opr1=2, sat=1 -> 0x80000000, cc=10.
- r_sel=1, imm_sel=1, imm16=0xFFE3, opr0=7 -> rslt=21, cc=00; opr0=0 -> rslt=0, cc=01.
- tag=1, gen=0x00A, r_sel=1, imm_sel=0, imm16=0x0FFF, opr0=0x12345678 -> rslt=0x12345678, rslt_tag=0xFF6, cc=10.
- Back-to-back stream of 6 ops, out_ready low for 4 cycles after the first out_valid -> in_ready low once 3 ops are held, all 6 results in order, none lost or duplicated. With MUL_ACC_EN: 3×4 with acc=0, then 5×6 with acc=1 -> 12, then 42.
- rst_n asserted with 2 ops in flight -> out_valid=0 and all outputs 0 immediately; after release, a new op 2×3 -> 6 with latency 3.
